// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the imem request handshake and the IF/ID register.
// A one-entry hold buffer absorbs a word that returns during a stall, so it is never refetched.
module if_stage #(
    parameter int                     PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter logic [31:0]            NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_write,
    input  logic                ifid_write,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ifid_instr,
    output logic [PC_WIDTH-1:0] ifid_pc4,
    output logic                ifid_valid,
    output logic [15:0]         stall_count
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc4;
    } hold_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pending_pc;
    hold_t               hold_buf;

    logic                stall;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] target;

    assign stall    = !pc_write || !ifid_write;
    assign pc_plus4 = pc + PC_WIDTH'(4);
    assign target   = redirect_pc & ~PC_WIDTH'(3);

    // Request is gated by rst_n so it drops immediately on async reset assertion.
    assign imem_req  = rst_n && (state != HOLD);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending_pc  <= '0;
            hold_buf    <= '0;
            ifid_instr  <= NOP_INSTR;
            ifid_pc4    <= '0;
            ifid_valid  <= 1'b0;
            stall_count <= '0;
        end else begin
            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;

            if (redirect) begin
                // Flush wins over ifid_write=0; the held word is dropped with it.
                ifid_instr <= NOP_INSTR;
                ifid_pc4   <= '0;
                ifid_valid <= 1'b0;
                hold_buf   <= '0;
                if (state != HOLD && !imem_ready) begin
                    // Outstanding request: keep the address stable until it completes.
                    pending_pc <= target;
                    state      <= DISCARD;
                end else begin
                    pc    <= target;
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_ready) begin
                            pc <= pc_plus4;
                            if (!stall) begin
                                ifid_instr <= imem_rdata;
                                ifid_pc4   <= pc_plus4;
                                ifid_valid <= 1'b1;
                            end else begin
                                hold_buf <= '{instr: imem_rdata, pc4: pc_plus4};
                                state    <= HOLD;
                            end
                        end else if (!stall) begin
                            ifid_valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            ifid_instr <= hold_buf.instr;
                            ifid_pc4   <= hold_buf.pc4;
                            ifid_valid <= 1'b1;
                            hold_buf   <= '0;
                            state      <= FETCH;
                        end
                    end
                    DISCARD: begin
                        if (imem_ready) begin
                            pc    <= pending_pc;
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: table of per-cycle stimulus with expected fetch/IF-ID values,
// plus hand sequences for stall saturation and reset asserted mid-HOLD.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, ifid_write, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = w(imem_addr);

    if_stage #(.PC_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
        .stall_count(stall_count)
    );

    typedef struct {
        logic        st;      // drives pc_write=ifid_write=0
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_scnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic e_valid, input logic [15:0] e_scnt);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_scnt = e_scnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
        pc_write    = !st;
        ifid_write  = !st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
        chk({tag, ".instr"}, ifid_instr, instr);
        chk({tag, ".pc4"},   ifid_pc4,   pc4);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    endtask

    initial begin
        // st rd rpc          rdy req addr          instr             pc4           v  scnt
        add(0, 0, 0,            1, 1, 32'h0,        w(32'h0),         32'h4,        1, 0);
        add(0, 0, 0,            1, 1, 32'h4,        w(32'h4),         32'h8,        1, 0);
        add(1, 0, 0,            1, 1, 32'h8,        w(32'h4),         32'h8,        1, 1);
        add(1, 0, 0,            1, 0, 32'hC,        w(32'h4),         32'h8,        1, 2);
        add(0, 0, 0,            1, 0, 32'hC,        w(32'h8),         32'hC,        1, 2);
        add(0, 0, 0,            1, 1, 32'hC,        w(32'hC),         32'h10,       1, 2);
        add(1, 0, 0,            1, 1, 32'h10,       w(32'hC),         32'h10,       1, 3);
        add(1, 1, 32'h40,       1, 0, 32'h14,       NOP,              32'h0,        0, 4);
        add(0, 0, 0,            1, 1, 32'h40,       w(32'h40),        32'h44,       1, 4);
        add(0, 0, 0,            1, 1, 32'h44,       w(32'h44),        32'h48,       1, 4);
        add(0, 1, 32'h10,       1, 1, 32'h48,       NOP,              32'h0,        0, 4);
        add(0, 0, 0,            0, 1, 32'h10,       NOP,              32'h0,        0, 4);
        add(0, 1, 32'h80,       0, 1, 32'h10,       NOP,              32'h0,        0, 4);
        add(0, 0, 0,            0, 1, 32'h10,       NOP,              32'h0,        0, 4);
        add(0, 0, 0,            1, 1, 32'h10,       NOP,              32'h0,        0, 4);
        add(0, 0, 0,            1, 1, 32'h80,       w(32'h80),        32'h84,       1, 4);
        add(0, 1, 32'hFFFF_FFFC,1, 1, 32'h84,       NOP,              32'h0,        0, 4);
        add(0, 0, 0,            1, 1, 32'hFFFF_FFFC,w(32'hFFFF_FFFC), 32'h0,        1, 4);
        add(0, 1, 32'h103,      1, 1, 32'h0,        NOP,              32'h0,        0, 4);
        add(0, 0, 0,            1, 1, 32'h100,      w(32'h100),       32'h104,      1, 4);
        add(1, 0, 0,            0, 1, 32'h104,      w(32'h100),       32'h104,      1, 5);
        add(0, 0, 0,            1, 1, 32'h104,      w(32'h104),       32'h108,      1, 5);

        drive(0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk_ifid("rst", NOP, 32'h0, 1'b0);
        chk("rst.scnt", {16'd0, stall_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (i != 0) @(negedge clk);
            drive(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
            #1;
            chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req) chk({tag, ".addr"}, imem_addr, vecs[i].e_addr);
            @(posedge clk);
            #1;
            chk_ifid(tag, vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid);
            chk({tag, ".scnt"}, {16'd0, stall_count}, {16'd0, vecs[i].e_scnt});
        end

        // Stall counter saturates rather than wrapping.
        @(negedge clk);
        drive(1, 0, 0, 0);
        repeat (65540) @(negedge clk);
        chk("sat.scnt", {16'd0, stall_count}, 32'h0000_FFFF);

        // Reset asserted mid-HOLD while stalled: outputs go to reset values immediately.
        drive(0, 0, 0, 1);
        @(negedge clk);
        drive(1, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("hold.req", {31'd0, imem_req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.req", {31'd0, imem_req}, 32'd0);
        chk_ifid("mrst", NOP, 32'h0, 1'b0);
        chk("mrst.scnt", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 1);
        rst_n = 1'b1;
        #1;
        chk("post.req",  {31'd0, imem_req}, 32'd1);
        chk("post.addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk_ifid("post", w(32'h0), 32'h4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
